multicycle_control: RTL
=======================

# multicycle_control

Multicycle main control FSM for the MIPS-subset datapath. It decodes the instruction opcode and sequences one instruction over 2–5 cycles, with stalls for memory. It drives the 3-bit `selAlu` code that the ALU-control decoder consumes, and it produces every datapath strobe: PC, IR, memory, register file and ALU operand select. It sits between the instruction register and the datapath, and it is the only source of `selAlu`.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction bits [31:26] from the IR; valid from the DECODE state onward.
- `memReady` in 1: memory completion; sampled in FETCH and MEM.
- `selAlu` out 3: ALU operation class. 000 = R-type (func decides), 001 = add, 010 = or, 011 = and, 100 = slt, 101 = sub/compare.
- `aluSrcB` out 2: ALU operand B. 00 = rt, 01 = sign-extended immediate, 10 = zero-extended immediate.
- `irWrite`, `pcWrite`, `pcWriteCond` out 1 each: IR load, unconditional PC load, PC load if ALU zero.
- `pcSrc` out 2: 00 = PC+4, 01 = branch target, 10 = jump target.
- `memRead`, `memWrite` out 1 each: memory strobes.
- `memToReg`, `regDst`, `regWrite` out 1 each: write-back controls.
- `instrDone` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: sticky flag, set on an unsupported opcode.
- `instrCount` out 16: count of retired instructions, wraps modulo 2^16.

## Operation
- Opcodes:
  - R 000000
  - ADDI 001000
  - ORI 001101
  - ANDI 001100
  - SLTI 001010
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: all outputs 0. Unconditionally → FETCH.
- FETCH:
  - `memRead`=1 throughout.
  - Stays in FETCH while `memReady`=0.
  - In the cycle with `memReady`=1: `irWrite`=1, `pcWrite`=1, `pcSrc`=00, then → DECODE.
- DECODE: latches `opcode` into an internal register, which all later states use.
  - J: `pcWrite`=1, `pcSrc`=10, `instrDone`=1, → FETCH.
  - Illegal opcode: sets `illegal`, asserts no strobes, no `instrDone`, → FETCH.
  - Otherwise → EXEC.
- EXEC: `selAlu` and `aluSrcB` per class:
  - R: 000 / 00.
  - ADDI, LW, SW: 001 / 01.
  - ORI: 010 / 10.
  - ANDI: 011 / 10.
  - SLTI: 100 / 01.
  - BEQ: 101 / 00, with `pcWriteCond`=1, `pcSrc`=01, `instrDone`=1, → FETCH.
  - LW and SW → MEM. All others → WB.
- MEM:
  - LW: `memRead`=1. SW: `memWrite`=1. The strobe is held until `memReady`=1.
  - SW completes here with `instrDone`=1, → FETCH.
  - LW → WB.
- WB: `regWrite`=1, `instrDone`=1, → FETCH.
  - `regDst`=1 for R-type only.
  - `memToReg`=1 for LW only.
- `selAlu` and `aluSrcB` are held at their EXEC values through MEM and WB, so the ALU result stays stable. They are 000 / 00 in all other states.
- `instrCount` increments on every cycle with `instrDone`=1. Illegal opcodes never retire.
- `illegal` clears only on reset. Execution continues after it is set.

## Timing
- Reset:
  - Asynchronous assertion forces IDLE.
  - All outputs, including `instrCount` and `illegal`, are 0 while reset is low and in the first cycle after release.
  - Reset mid-instruction aborts the instruction with no write strobe asserted after reset asserts.
- Outputs are Moore-style: a function of state, the latched opcode and `memReady`. No output depends combinationally on `opcode` outside DECODE.
- Cycle counts with `memReady` high in every sampled cycle:

  | Instruction | Cycles |
  |---|---|
  | J, illegal | 2 |
  | BEQ | 3 |
  | R-type, immediates, SW | 4 |
  | LW | 5 |

- Each cycle `memReady` is low in FETCH or MEM adds one cycle. Strobes are held constant across the stall.
- `memReady` high outside FETCH and MEM is ignored.
- `instrCount` at 0xFFFF plus one retire → 0x0000, with no flag.

## Test plan
- Reset then R-type 000000 with `memReady`=1:
  - IDLE→FETCH→DECODE→EXEC→WB.
  - `selAlu`=000 in EXEC.
  - `regWrite`=`regDst`=1 in WB.
  - `instrCount`=1.
- LW with `memReady` low for 3 cycles in MEM:
  - `memRead` held for 4 MEM cycles, then WB with `memToReg`=1.
  - Total 8 cycles.
- ORI, ANDI, SLTI, ADDI sequence:
  - EXEC shows `selAlu` 010, 011, 100, 001.
  - `aluSrcB` 10, 10, 01, 01.
  - `instrCount`=4 after 16 cycles.
- BEQ, then J:
  - BEQ: `pcWriteCond`=1, `pcSrc`=01, `selAlu`=101 in its 3rd cycle.
  - J: `pcWrite`=1, `pcSrc`=10 in DECODE.
  - `instrCount`=2.
- Opcode 111111:
  - `illegal` goes 1 and stays 1, `instrCount` is unchanged, next FETCH follows.
  - A subsequent SW retires normally.
- `rst_n` low during the MEM state of SW:
  - `memWrite` drops immediately and all outputs are 0.
  - After release: IDLE, then FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the MIPS-subset datapath: sequences each
// instruction over 2-5 cycles and drives every datapath strobe plus selAlu.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        memReady,
    output logic [2:0]  selAlu,
    output logic [1:0]  aluSrcB,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic [1:0]  pcSrc,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic        regDst,
    output logic        regWrite,
    output logic        instrDone,
    output logic        illegal,
    output logic [15:0] instrCount
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned PCS_W = 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
    localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
    localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;

    localparam logic [ALU_W-1:0] ALU_RTYPE = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR    = 3'b010;
    localparam logic [ALU_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT   = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'b101;

    localparam logic [SRC_W-1:0] SRC_RT   = 2'b00;
    localparam logic [SRC_W-1:0] SRC_SEXT = 2'b01;
    localparam logic [SRC_W-1:0] SRC_ZEXT = 2'b10;

    localparam logic [PCS_W-1:0] PC_INC    = 2'b00;
    localparam logic [PCS_W-1:0] PC_BRANCH = 2'b01;
    localparam logic [PCS_W-1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [OP_W-1:0]    r_op;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_count;

    logic               w_legal;
    logic               w_set_illegal;
    logic [ALU_W-1:0]   w_alu_sel;
    logic [SRC_W-1:0]   w_alu_src;

    // Opcode legality, judged on the live IR bits during DECODE
    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OP_R, OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI,
            OP_LW, OP_SW, OP_BEQ, OP_J: w_legal = 1'b1;
            default:                    w_legal = 1'b0;
        endcase
    end

    // ALU class from the latched opcode; held from EXEC through WB
    always_comb begin
        w_alu_sel = ALU_RTYPE;
        w_alu_src = SRC_RT;
        case (r_op)
            OP_ADDI, OP_LW, OP_SW: begin
                w_alu_sel = ALU_ADD;
                w_alu_src = SRC_SEXT;
            end
            OP_ORI: begin
                w_alu_sel = ALU_OR;
                w_alu_src = SRC_ZEXT;
            end
            OP_ANDI: begin
                w_alu_sel = ALU_AND;
                w_alu_src = SRC_ZEXT;
            end
            OP_SLTI: begin
                w_alu_sel = ALU_SLT;
                w_alu_src = SRC_SEXT;
            end
            OP_BEQ: begin
                w_alu_sel = ALU_SUB;
                w_alu_src = SRC_RT;
            end
            default: begin
                w_alu_sel = ALU_RTYPE;
                w_alu_src = SRC_RT;
            end
        endcase
    end

    // Next state and strobes; outputs decode from state, latched opcode and memReady
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        selAlu        = ALU_RTYPE;
        aluSrcB       = SRC_RT;
        irWrite       = 1'b0;
        pcWrite       = 1'b0;
        pcWriteCond   = 1'b0;
        pcSrc         = PC_INC;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        memToReg      = 1'b0;
        regDst        = 1'b0;
        regWrite      = 1'b0;
        instrDone     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    pcSrc   = PC_INC;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_J) begin
                    pcWrite   = 1'b1;
                    pcSrc     = PC_JUMP;
                    instrDone = 1'b1;
                    w_next    = S_FETCH;
                end else if (!w_legal) begin
                    w_set_illegal = 1'b1;
                    w_next        = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                selAlu  = w_alu_sel;
                aluSrcB = w_alu_src;
                if (r_op == OP_BEQ) begin
                    pcWriteCond = 1'b1;
                    pcSrc       = PC_BRANCH;
                    instrDone   = 1'b1;
                    w_next      = S_FETCH;
                end else if (r_op == OP_LW || r_op == OP_SW) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                selAlu  = w_alu_sel;
                aluSrcB = w_alu_src;
                if (r_op == OP_LW) begin
                    memRead = 1'b1;
                end else begin
                    memWrite = 1'b1;
                end
                if (memReady) begin
                    if (r_op == OP_LW) begin
                        w_next = S_WB;
                    end else begin
                        instrDone = 1'b1;
                        w_next    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                selAlu    = w_alu_sel;
                aluSrcB   = w_alu_src;
                regWrite  = 1'b1;
                instrDone = 1'b1;
                regDst    = (r_op == OP_R);
                memToReg  = (r_op == OP_LW);
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, latched opcode, sticky illegal flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (instrDone) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign illegal    = r_illegal;
    assign instrCount = r_count;

endmodule
